// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin arbitrated multiplexer.
package mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Pointer value that follows idx, wrapping back to 0 after the last channel.
    function automatic int next_ptr(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: picks one requester, either searching from ptr with
// wrap-around (round-robin) or from index 0 (fixed priority).
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 mode,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int SW = $clog2(N);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_shift;
    logic [N-1:0]   req_rot;
    int             base;
    int             win;
    logic           found;

    // Doubling the request vector lets a plain right shift act as a rotation,
    // so the first set bit of the rotated vector is the winner's offset from base.
    always_comb begin
        base      = (mode == MODE_FIXED) ? 0 : int'(ptr);
        req_dbl   = {req, req};
        req_shift = req_dbl >> base;
        req_rot   = req_shift[N-1:0];
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        win       = 0;
        for (int j = 0; j < N; j++) begin
            if (!found && req_rot[j]) begin
                found     = 1'b1;
                win       = (base + j) % N;
                grant_idx = SW'(win);
                grant[win] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N:1 multiplexer with a registered output, valid/ready on every port, and an
// internal arbiter choosing the source channel for each transfer.
module rr_mux_arb
    import mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_sel
);

    localparam int SW = $clog2(N);

    logic [SW-1:0] rr_ptr;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic          load;
    logic          in_xfer;
    logic [W-1:0]  win_data;

    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .mode      (mode),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The output register can take a new word when empty or being drained this cycle;
    // in_ready is forced low during reset so no channel sees a spurious handshake.
    always_comb begin
        load     = ~out_valid | out_ready;
        in_ready = rst ? '0 : (grant & {N{load}});
        in_xfer  = |in_ready;
    end

    // Steer the granted channel's word toward the output register.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) win_data = in_data[i*W +: W];
        end
    end

    // Output register and round-robin pointer; pointer only advances in round-robin mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_sel   <= grant_idx;
            if (mode == MODE_RR) rr_ptr <= SW'(next_ptr(int'(grant_idx), N));
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Self-checking bench for rr_mux_arb (N=4, W=8) using a reference model and a
// scoreboard queue of expected output words.
module tb_rr_mux_arb;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   sel;
    } sb_item_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_sel;

    int total = 0;
    int bad   = 0;

    sb_item_t sb[$];
    int       m_ptr   = 0;
    logic     m_valid = 1'b0;

    rr_mux_arb #(.N(N), .W(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    // At most one channel may ever see in_ready.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (!$onehot0(in_ready)) begin
                bad++;
                $display("[TB] FAIL onehot_in_ready got=%b need=onehot0", in_ready);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference arbiter: linear search starting at ptr (or 0 in fixed mode).
    function automatic int model_winner(input logic [N-1:0] v, input logic m, input int ptr);
        int start;
        start = m ? 0 : ptr;
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Advance the reference model by one cycle from the current inputs and
    // queue the word the DUT should present after the next edge.
    task automatic advance_model(output logic [N-1:0] exp_ready, output bit pushed);
        int       g;
        bit       ld;
        sb_item_t it;
        g         = model_winner(in_valid, mode, m_ptr);
        ld        = !m_valid || out_ready;
        exp_ready = '0;
        pushed    = 1'b0;
        if (ld && g >= 0) begin
            exp_ready[g] = 1'b1;
            it.data = in_data[g*W +: W];
            it.sel  = 2'(g);
            sb.push_back(it);
            pushed  = 1'b1;
            m_valid = 1'b1;
            if (mode == 1'b0) m_ptr = (g + 1) % N;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        logic [N-1:0] er;
        bit           p;
        sb_item_t     it;
        rst = 1'b1; mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b need=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_data got=%h need=00", out_data); end
        total++; if (out_sel !== 2'd0) begin bad++; $display("[TB] FAIL reset_out_sel got=%0d need=0", out_sel); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_in_ready got=%b need=0000", in_ready); end
        rst = 1'b0;
        model_reset();
        in_valid = 4'b0001; in_data[7:0] = 8'h3C;
        #1;
        advance_model(er, p);
        total++; if (in_ready !== er) begin bad++; $display("[TB] FAIL reset_load_ready got=%b need=%b", in_ready, er); end
        @(posedge clk); #1;
        it = sb.pop_front();
        total++; if (out_valid !== 1'b1 || out_data !== it.data) begin bad++; $display("[TB] FAIL reset_load_word got=%b/%h need=1/%h", out_valid, out_data, it.data); end
        #1;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL async_out_valid got=%b need=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL async_out_data got=%h need=00", out_data); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL async_in_ready got=%b need=0000", in_ready); end
        @(negedge clk);
        rst = 1'b0; in_valid = '0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_rr_fairness();
        logic [N-1:0] er;
        bit           p;
        sb_item_t     it;
        int           seq[6] = '{0, 1, 2, 3, 0, 1};
        mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_data = {$urandom, $urandom} ;
            #1;
            advance_model(er, p);
            total++; if (in_ready !== er) begin bad++; $display("[TB] FAIL rr_ready c=%0d got=%b need=%b", c, in_ready, er); end
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                total++; bad++; $display("[TB] FAIL rr_scoreboard_empty c=%0d got=0 need=1 entries", c);
            end else begin
                it = sb.pop_front();
                total++; if (out_valid !== 1'b1 || out_data !== it.data || out_sel !== it.sel) begin bad++; $display("[TB] FAIL rr_word c=%0d got=%b/%h/%0d need=1/%h/%0d", c, out_valid, out_data, out_sel, it.data, it.sel); end
            end
            total++; if (int'(out_sel) != seq[c]) begin bad++; $display("[TB] FAIL rr_seq c=%0d got=%0d need=%0d", c, out_sel, seq[c]); end
        end
    endtask

    task automatic test_wrap_skip();
        logic [N-1:0] er;
        bit           p;
        sb_item_t     it;
        int           exp_sel[3] = '{0, 2, 0};
        int           exp_ptr[3] = '{1, 3, 1};
        mode = 1'b0; out_ready = 1'b1;
        in_valid = 4'b0100; in_data = 32'h44332211;
        #1;
        advance_model(er, p);
        @(posedge clk); #1;
        it = sb.pop_front();
        total++; if (u_dut.rr_ptr !== 2'd3) begin bad++; $display("[TB] FAIL wrap_setup_ptr got=%0d need=3", u_dut.rr_ptr); end
        in_valid = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            in_data = {$urandom};
            #1;
            advance_model(er, p);
            total++; if (in_ready !== er) begin bad++; $display("[TB] FAIL wrap_ready c=%0d got=%b need=%b", c, in_ready, er); end
            @(posedge clk); #1;
            it = sb.pop_front();
            total++; if (out_data !== it.data || out_sel !== it.sel) begin bad++; $display("[TB] FAIL wrap_word c=%0d got=%h/%0d need=%h/%0d", c, out_data, out_sel, it.data, it.sel); end
            total++; if (int'(out_sel) != exp_sel[c]) begin bad++; $display("[TB] FAIL wrap_sel c=%0d got=%0d need=%0d", c, out_sel, exp_sel[c]); end
            total++; if (int'(u_dut.rr_ptr) != exp_ptr[c]) begin bad++; $display("[TB] FAIL wrap_ptr c=%0d got=%0d need=%0d", c, u_dut.rr_ptr, exp_ptr[c]); end
        end
    endtask

    task automatic test_fixed_priority();
        logic [N-1:0] er;
        bit           p;
        sb_item_t     it;
        mode = 1'b1; in_valid = 4'b1110; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = {$urandom};
            #1;
            advance_model(er, p);
            total++; if (in_ready !== 4'b0010 || in_ready !== er) begin bad++; $display("[TB] FAIL fixed_ready c=%0d got=%b need=0010", c, in_ready); end
            @(posedge clk); #1;
            it = sb.pop_front();
            total++; if (out_sel !== 2'd1 || out_data !== it.data) begin bad++; $display("[TB] FAIL fixed_word c=%0d got=%0d/%h need=1/%h", c, out_sel, out_data, it.data); end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] er;
        bit           p;
        sb_item_t     it;
        mode = 1'b0; out_ready = 1'b1; in_valid = 4'b0001;
        in_data = {8'h77, 8'h66, 8'h55, 8'hA5};
        #1;
        advance_model(er, p);
        @(posedge clk); #1;
        it = sb.pop_front();
        total++; if (out_data !== 8'hA5) begin bad++; $display("[TB] FAIL bp_load got=%h need=a5", out_data); end
        out_ready = 1'b0; in_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            advance_model(er, p);
            total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL bp_ready c=%0d got=%b need=0000", c, in_ready); end
            @(posedge clk); #1;
            total++; if (out_data !== 8'hA5 || out_valid !== 1'b1 || out_sel !== 2'd0) begin bad++; $display("[TB] FAIL bp_hold c=%0d got=%b/%h/%0d need=1/a5/0", c, out_valid, out_data, out_sel); end
        end
        out_ready = 1'b1;
        #1;
        advance_model(er, p);
        total++; if (in_ready !== er || er === 4'b0000) begin bad++; $display("[TB] FAIL bp_release_ready got=%b need=%b", in_ready, er); end
        @(posedge clk); #1;
        it = sb.pop_front();
        total++; if (out_data !== it.data || out_sel !== it.sel || out_data !== 8'h55) begin bad++; $display("[TB] FAIL bp_release_word got=%h/%0d need=%h/%0d", out_data, out_sel, it.data, it.sel); end
    endtask

    task automatic test_idle_drain();
        logic [N-1:0] er;
        bit           p;
        sb_item_t     it;
        int           valid_cycles;
        mode = 1'b0; out_ready = 1'b1; in_valid = '0;
        #1;
        advance_model(er, p);
        @(posedge clk); #1;
        in_valid = 4'b0100; in_data = {8'h04, 8'hC2, 8'h02, 8'h01};
        #1;
        advance_model(er, p);
        total++; if (in_ready !== 4'b0100) begin bad++; $display("[TB] FAIL drain_ready got=%b need=0100", in_ready); end
        @(posedge clk); #1;
        in_valid = '0;
        it = sb.pop_front();
        total++; if (out_data !== 8'hC2 || out_sel !== 2'd2 || out_data !== it.data) begin bad++; $display("[TB] FAIL drain_word got=%h/%0d need=c2/2", out_data, out_sel); end
        valid_cycles = (out_valid === 1'b1) ? 1 : 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            advance_model(er, p);
            total++; if (in_ready !== 4'b0000) begin bad++; $display("[TB] FAIL drain_idle_ready c=%0d got=%b need=0000", c, in_ready); end
            @(posedge clk); #1;
            if (out_valid === 1'b1) valid_cycles++;
            total++; if (out_valid !== m_valid) begin bad++; $display("[TB] FAIL drain_valid c=%0d got=%b need=%b", c, out_valid, m_valid); end
        end
        total++; if (valid_cycles != 1) begin bad++; $display("[TB] FAIL drain_valid_count got=%0d need=1", valid_cycles); end
        total++; if (out_data !== 8'hC2 || out_sel !== 2'd2) begin bad++; $display("[TB] FAIL drain_hold got=%h/%0d need=c2/2", out_data, out_sel); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] starting rr_mux_arb bench");
        test_reset();
        test_rr_fairness();
        test_wrap_skip();
        test_fixed_priority();
        test_backpressure();
        test_idle_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
